// File: rtl/cache_arbiter_if.sv
// Whole-line physical-memory port bundle shared by the I-cache, D-cache and memory sides.
// The side that issues commands takes the master modport, the side that services them takes slave.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [LINE_WIDTH-1:0] wdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic                  resp;

    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serializing I-cache and D-cache line misses onto one physical memory port.
// A one-cycle RELEASE after every completion lets the serviced cache drop its level request.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    cache_arbiter_if.slave   i_bus,
    cache_arbiter_if.slave   d_bus,
    cache_arbiter_if.master  mem_bus,
    output logic             grant_i,
    output logic             grant_d
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
    typedef enum logic {SIDE_I, SIDE_D} side_t;

    state_t                state, state_next;
    side_t                 last_grant, last_grant_next;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_next;
    logic                  read_q, read_next;
    logic                  write_q, write_next;
    logic                  i_req, d_req;
    logic                  unused_i_write;

    assign i_req = i_bus.read;
    assign d_req = d_bus.read | d_bus.write;

    // The I-cache never writes back; its write half of the bundle is intentionally ignored.
    assign unused_i_write = ^{i_bus.write, i_bus.wdata};

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= SIDE_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            read_q     <= read_next;
            write_q    <= write_next;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        read_next       = read_q;
        write_next      = write_q;
        case (state)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (i_req && (!d_req || last_grant == SIDE_D)) begin
                    state_next      = GRANT_I;
                    last_grant_next = SIDE_I;
                    addr_next       = i_bus.address;
                    wdata_next      = '0;
                    read_next       = 1'b1;
                    write_next      = 1'b0;
                end else if (d_req) begin
                    state_next      = GRANT_D;
                    last_grant_next = SIDE_D;
                    addr_next       = d_bus.address;
                    wdata_next      = d_bus.wdata;
                    // An illegal read+write collapses to a write-back only.
                    write_next      = d_bus.write;
                    read_next       = ~d_bus.write;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_bus.resp) state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_i = (state == GRANT_I);
    assign grant_d = (state == GRANT_D);

    assign mem_bus.read    = (grant_i | grant_d) & read_q;
    assign mem_bus.write   = (grant_i | grant_d) & write_q;
    assign mem_bus.address = addr_q;
    assign mem_bus.wdata   = wdata_q;

    assign i_bus.rdata = mem_bus.rdata;
    assign d_bus.rdata = mem_bus.rdata;
    assign i_bus.resp  = grant_i & mem_bus.resp;
    assign d_bus.resp  = grant_d & mem_bus.resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios followed by randomized request traffic
// checked against a transaction-level model of round-robin arbitration and a fixed-latency memory.
module tb_cache_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic reset;
    logic grant_i, grant_d;

    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) i_bus ();
    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) d_bus ();
    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) mem_bus ();

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_bus   (i_bus),
        .d_bus   (d_bus),
        .mem_bus (mem_bus),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: outstanding cache requests and who won the previous arbitration.
    bit          pend_i, pend_d;
    bit          d_rd, d_wr;
    bit          last_was_d;
    logic [AW-1:0] a_i, a_d;
    logic [LW-1:0] w_d;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_reqs();
        i_bus.read    = pend_i;
        i_bus.write   = 1'b0;
        i_bus.address = a_i;
        i_bus.wdata   = '0;
        d_bus.read    = pend_d & d_rd;
        d_bus.write   = pend_d & d_wr;
        d_bus.address = a_d;
        d_bus.wdata   = w_d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        pend_i = 1'b0;
        pend_d = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
        a_i    = '0;
        a_d    = '0;
        w_d    = '0;
        drive_reqs();
        mem_bus.resp  = 1'b0;
        mem_bus.rdata = '0;
        last_was_d    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One cycle in IDLE with the current requests presented; nothing may be issued or answered.
    task automatic idle_step(input bit spur);
        @(negedge clk);
        drive_reqs();
        mem_bus.resp  = spur;
        mem_bus.rdata = rand_line();
        #1;
        check("idle_grant_i", grant_i, 1'b0);
        check("idle_grant_d", grant_d, 1'b0);
        check("idle_read", mem_bus.read, 1'b0);
        check("idle_write", mem_bus.write, 1'b0);
        check("idle_i_resp", i_bus.resp, 1'b0);
        check("idle_d_resp", d_bus.resp, 1'b0);
    endtask

    // Called right after an IDLE cycle that presented requests: runs grant, response and release.
    task automatic serve(input int lat, input bit garble, input bit hold,
                         input bit rd_fixed, input logic [LW-1:0] rd_val);
        bit            win_i, ewr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ew, rd;
        win_i      = pend_i && (!pend_d || last_was_d);
        last_was_d = !win_i;
        ea  = win_i ? a_i : a_d;
        ew  = win_i ? '0 : w_d;
        ewr = win_i ? 1'b0 : d_wr;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (garble && c == 0) begin
                // The requester wanders off mid-grant; the latched command must not notice.
                if (win_i) begin
                    i_bus.read    = 1'b0;
                    i_bus.address = AW'($urandom);
                end else begin
                    d_bus.read    = 1'b0;
                    d_bus.write   = 1'b0;
                    d_bus.address = AW'($urandom);
                    d_bus.wdata   = rand_line();
                end
            end
            mem_bus.resp  = (c == lat);
            mem_bus.rdata = rd_fixed ? rd_val : rand_line();
            rd = mem_bus.rdata;
            #1;
            check("grant_i", grant_i, win_i);
            check("grant_d", grant_d, !win_i);
            check("pmem_read", mem_bus.read, !ewr);
            check("pmem_write", mem_bus.write, ewr);
            check("pmem_address", mem_bus.address, ea);
            if (!win_i) check("pmem_wdata", mem_bus.wdata, ew);
            check("i_resp", i_bus.resp, win_i && (c == lat));
            check("d_resp", d_bus.resp, !win_i && (c == lat));
            check("i_rdata", i_bus.rdata, rd);
            check("d_rdata", d_bus.rdata, rd);
        end
        @(negedge clk);
        if (!hold) begin
            if (win_i) pend_i = 1'b0;
            else       pend_d = 1'b0;
        end
        drive_reqs();
        mem_bus.resp = 1'($urandom_range(0, 1));
        #1;
        check("rel_read", mem_bus.read, 1'b0);
        check("rel_write", mem_bus.write, 1'b0);
        check("rel_grant_i", grant_i, 1'b0);
        check("rel_grant_d", grant_d, 1'b0);
        check("rel_i_resp", i_bus.resp, 1'b0);
        check("rel_d_resp", d_bus.resp, 1'b0);
    endtask

    initial begin
        logic [LW-1:0] r;

        // Reset then five quiet cycles: everything zero, rdata follows memory.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_bus.rdata = rand_line();
            r = mem_bus.rdata;
            #1;
            check("rst_read", mem_bus.read, 1'b0);
            check("rst_write", mem_bus.write, 1'b0);
            check("rst_address", mem_bus.address, '0);
            check("rst_wdata", mem_bus.wdata, '0);
            check("rst_grants", {grant_i, grant_d}, 2'b00);
            check("rst_resps", {i_bus.resp, d_bus.resp}, 2'b00);
            check("rst_i_rdata", i_bus.rdata, r);
            check("rst_d_rdata", d_bus.rdata, r);
        end

        // Single I read of 0x1230 answered after four cycles with an A5 pattern.
        pend_i = 1'b1;
        a_i    = 16'h1230;
        idle_step(1'b0);
        serve(4, 1'b0, 1'b0, 1'b1, {16{8'hA5}});

        // Both sides reading from reset and holding: grants alternate starting with I.
        do_reset();
        pend_i = 1'b1; a_i = 16'h0100;
        pend_d = 1'b1; a_d = 16'h0200; d_rd = 1'b1; d_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle_step(1'b0);
            serve(1, 1'b0, 1'b1, 1'b0, '0);
        end
        pend_i = 1'b0;
        pend_d = 1'b0;

        // D write-back with the requester scribbling over its inputs mid-grant.
        pend_d = 1'b1; a_d = 16'h4000; d_rd = 1'b0; d_wr = 1'b1;
        w_d    = {2{64'h0123_4567_89AB_CDEF}};
        idle_step(1'b0);
        serve(3, 1'b1, 1'b0, 1'b0, '0);

        // Illegal read+write from the D-cache issues a write only.
        pend_d = 1'b1; a_d = 16'h5550; d_rd = 1'b1; d_wr = 1'b1;
        w_d    = rand_line();
        idle_step(1'b0);
        serve(2, 1'b0, 1'b0, 1'b0, '0);

        // Reset two cycles into GRANT_D, coinciding with a response, then a stale response.
        pend_d = 1'b1; a_d = 16'h7770; d_rd = 1'b0; d_wr = 1'b1;
        w_d    = rand_line();
        idle_step(1'b0);
        @(negedge clk);
        #1;
        check("rg_grant_d", grant_d, 1'b1);
        check("rg_write", mem_bus.write, 1'b1);
        @(negedge clk);
        reset        = 1'b1;
        mem_bus.resp = 1'b1;
        #1;
        check("rg_same_cycle_d_resp", d_bus.resp, 1'b1);
        @(negedge clk);
        reset  = 1'b0;
        pend_d = 1'b0;
        drive_reqs();
        mem_bus.resp = 1'b1;
        last_was_d   = 1'b1;
        #1;
        check("rg_grants", {grant_i, grant_d}, 2'b00);
        check("rg_cmds", {mem_bus.read, mem_bus.write}, 2'b00);
        check("rg_address", mem_bus.address, '0);
        check("rg_wdata", mem_bus.wdata, '0);
        check("rg_stale_resps", {i_bus.resp, d_bus.resp}, 2'b00);

        // Randomized traffic: caches keep a request up until it is serviced.
        for (int n = 0; n < 80; n++) begin
            if (!pend_i && $urandom_range(0, 2) != 0) begin
                pend_i = 1'b1;
                a_i    = AW'($urandom);
            end
            if (!pend_d && $urandom_range(0, 2) != 0) begin
                pend_d = 1'b1;
                a_d    = AW'($urandom);
                w_d    = rand_line();
                case ($urandom_range(0, 3))
                    0:       begin d_rd = 1'b1; d_wr = 1'b0; end
                    1:       begin d_rd = 1'b0; d_wr = 1'b1; end
                    2:       begin d_rd = 1'b1; d_wr = 1'b1; end
                    default: begin d_rd = 1'b1; d_wr = 1'b0; end
                endcase
            end
            idle_step(1'($urandom_range(0, 1)));
            if (pend_i || pend_d)
                serve($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
